// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
// Owns HI/LO and models multi-cycle mult/div latency through busy.
// The result is computed when an operation is accepted and held in pend_*.
// It is committed to HI/LO on the last busy edge.
// Optional feature macro: MD_MADD_EN adds madd (op 9) and msub (op 10),
// which accumulate onto the HI/LO value present at the accepting edge.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_we;

  logic             acc_ok;
  logic [63:0]      res;
  logic             res_we;
  logic [CNT_W-1:0] load_cnt;

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    p  = sa * sb;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  // Signed divide done in sign/magnitude form so INT_MIN / -1 is well defined
  // (quotient wraps to 0x80000000, remainder 0). Returns {remainder, quotient}.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  // Unsigned divide. Returns {remainder, quotient}.
  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  // Decode the E-stage op into an acceptance flag, the pending result and its latency.
  always_comb begin
    acc_ok   = 1'b0;
    res      = 64'd0;
    res_we   = 1'b0;
    load_cnt = '0;
    case (op)
      OP_MULT: begin
        acc_ok   = 1'b1;
        res      = mul_s(A, B);
        res_we   = 1'b1;
        load_cnt = CNT_W'(MULT_CYCLES);
      end
      OP_MULTU: begin
        acc_ok   = 1'b1;
        res      = mul_u(A, B);
        res_we   = 1'b1;
        load_cnt = CNT_W'(MULT_CYCLES);
      end
      OP_DIV: begin
        acc_ok   = 1'b1;
        res_we   = (B != 32'd0);
        res      = res_we ? div_s(A, B) : 64'd0;
        load_cnt = CNT_W'(DIV_CYCLES);
      end
      OP_DIVU: begin
        acc_ok   = 1'b1;
        res_we   = (B != 32'd0);
        res      = res_we ? div_u(A, B) : 64'd0;
        load_cnt = CNT_W'(DIV_CYCLES);
      end
`ifdef MD_MADD_EN
      OP_MADD: begin
        acc_ok   = 1'b1;
        res      = {HI, LO} + mul_s(A, B);
        res_we   = 1'b1;
        load_cnt = CNT_W'(MULT_CYCLES);
      end
      OP_MSUB: begin
        acc_ok   = 1'b1;
        res      = {HI, LO} - mul_s(A, B);
        res_we   = 1'b1;
        load_cnt = CNT_W'(MULT_CYCLES);
      end
`endif
      default: begin
        acc_ok = 1'b0;
      end
    endcase
  end

  // Accept / count down / commit; mt writes only while idle and not starting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else if (cnt != '0) begin
      // ---- busy: count down, commit on the final edge ----
      cnt <= cnt - CNT_W'(1);
      if ((cnt == CNT_W'(1)) && pend_we) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (start) begin
      // ---- idle: accept a new mult/div ----
      if (acc_ok) begin
        cnt     <= load_cnt;
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_we <= res_we;
      end
    end else if (op == OP_MTLO) begin
      LO <= A;
    end else if (op == OP_MTHI) begin
      HI <= A;
    end
  end

  assign busy = (cnt != '0);

  // mf read path: current register contents, including the old value while busy.
  always_comb begin
    rd_data = 32'd0;
    if (op == OP_MFLO)      rd_data = LO;
    else if (op == OP_MFHI) rd_data = HI;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (default build, MD_MADD_EN undefined).
// Expected HI/LO/latency are pushed to a scoreboard when an op is driven.
// They are popped and compared when busy drops.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the architectural result; divide by zero keeps HI/LO.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa;
    longint sb2;
    int     ia;
    int     ib;
    longint p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ia  = a;
    ib  = b;
    case (o)
      4'd1: begin p = sa * sb2; return p; end
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: if (b == 32'd0) return {hi, lo}; else return {32'(ia % ib), 32'(ia / ib)};
      4'd4: if (b == 32'd0) return {hi, lo}; else return {a % b, a / b};
      default: return {hi, lo};
    endcase
  endfunction

  // Called while in busy cycle (base+1); counts remaining busy cycles and checks the popped result.
  task automatic wait_done(input int base);
    int   c;
    exp_t e;
    c = base;
    while (busy && c < 60) begin
      c++;
      tick();
    end
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("busy_cycles", 32'(c), 32'(e.cycles));
      check("HI", HI, e.hi);
      check("LO", LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int n);
    sb.push_back('{ehi, elo, n});
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    wait_done(0);
  endtask

  initial begin
    logic [63:0] m;
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);

    // Directed mult / multu / div cases
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    run_op(4'd4, 32'd12345, 32'd0, 32'h00000000, 32'h80000000, 10);
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);

    // Random mult/multu/div/divu against the model
    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if (i == 0) b = 32'd1;
      if (o >= 4'd3 && b == 32'd0) b = 32'd5;
      if (o == 4'd3 && a == 32'h80000000) a = 32'd1;
      m = model(o, a, b, m_hi, m_lo);
      run_op(o, a, b, m[63:32], m[31:0], (o <= 4'd2) ? 5 : 10);
    end

    // mthi then mtlo, then mf reads
    op = 4'd6; A = 32'h1234;
    tick();
    check("mthi_busy", {31'd0, busy}, 32'd0);
    op = 4'd5; A = 32'h5678;
    tick();
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    op = 4'd8; #1;
    check("mfhi", rd_data, 32'h1234);
    op = 4'd7; #1;
    check("mflo", rd_data, 32'h5678);
    op = 4'd0; #1;
    check("mf_none", rd_data, 32'd0);
    m_hi = 32'h1234; m_lo = 32'h5678;

    // divu with an mtlo and a second start issued while busy
    sb.push_back('{32'd2, 32'd14, 10});
    op = 4'd4; A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    check("divu_busy1", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    op = 4'd7; #1;
    check("mflo_while_busy", rd_data, 32'h5678);
    op = 4'd5; A = 32'hDEAD;
    tick();
    op = 4'd1; A = 32'd3; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    wait_done(5);

    // start held through completion: not accepted on the commit edge, accepted on the next
    sb.push_back('{32'd4, 32'd28, 10});
    op = 4'd4; A = 32'd200; B = 32'd7; start = 1'b1;
    tick();
    wait_done(0);
    tick();
    check("reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0; op = 4'd0;
    sb.push_back('{32'd4, 32'd28, 10});
    wait_done(0);

    // Reset during a mult aborts it
    op = 4'd1; A = 32'd3; B = 32'd5; start = 1'b1;
    tick();
    start = 1'b0; op = 4'd0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_HI", HI, 32'd0);
    check("abort_LO", LO, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_late_HI", HI, 32'd0);
      check("no_late_LO", LO, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the decoder's `start` and 4-bit `alupro_op`, plus forwarded rs/rt operands.
- Owns the HI/LO registers; models multi-cycle mult/div latency through `busy`.
- D-stage stall logic uses `start | busy` to hold any later md instruction.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10: busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is mult/multu/div/divu.
- op  input  4  1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 mflo, 8 mfhi, 0 none; others ignored.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- rd_data  output  32  mf read result.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, counter=0, pending results cleared. Reset mid-operation aborts the operation and no HI/LO write occurs.
- Internal state:
  - cnt, 4 bits, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - pend_hi, pend_lo, pend_we.
  - busy = (cnt != 0), driven by the register with no combinational path from start.
- Accepted start (start=1, cnt==0, op in 1..4), at that edge:
  - op sampled; A, B captured.
  - cnt loaded with MULT_CYCLES or DIV_CYCLES.
  - Result computed into pend_*.
- Completion: each edge with cnt!=0 decrements cnt. On the edge where cnt==1, HI/LO are written from pend_* (only if pend_we) and cnt becomes 0.
- Timing: start at edge k gives busy=1 in cycles k+1 .. k+N. New HI/LO are visible and busy=0 from cycle k+N+1.
- mult: {HI,LO} = signed A * signed B, 64-bit.
- multu: {HI,LO} = unsigned product.
- div (signed, truncates toward zero):
  - LO = quotient; HI = remainder with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (div or divu): full DIV_CYCLES busy, pend_we=0, HI/LO unchanged.
- mtlo/mthi with cnt==0: LO (or HI) = A at the edge; busy stays 0.
- start or mt while busy: ignored, with no state change; the stall logic must prevent this case.
- rd_data is combinational:
  - op==7 gives LO; op==8 gives HI; otherwise 0.
  - It reflects the current register values, including the old value while busy.
- start=1 with op outside 1..4 is ignored.
- Same cycle as completion: a new start is not accepted because cnt==1. Acceptance is possible in the following cycle.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: two extra op codes are decoded. start is accepted with these codes (caller asserts start); they take MULT_CYCLES, and the accumulate uses the HI/LO value captured at the accepted start.
  - 9 = madd: {HI,LO} += signed A*B, mod 2^64.
  - 10 = msub: {HI,LO} -= signed A*B, mod 2^64.
- Undefined: codes 9 and 10 are treated as unsupported and ignored; logic is identical to the base block.

Test Plan:
- Reset, then op=1/start with A=0xFFFFFFFE, B=3:
  - busy=1 for exactly 5 cycles.
  - Next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- op=2 (multu), same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- op=3 (div) A=0xFFFFFFF9 (-7), B=2:
  - 10 busy cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat with B=0: HI/LO unchanged after 10 cycles.
- mthi A=0x1234, then mtlo A=0x5678 on consecutive cycles:
  - busy stays 0.
  - op=8 gives rd_data=0x1234; op=7 gives 0x5678.
  - op=0 gives rd_data=0.
- Start divu A=100, B=7; at busy cycle 4 assert mtlo and a second start -> both ignored; final LO=14, HI=2.
- Start mult; assert reset at busy cycle 3:
  - Next cycle busy=0, HI=LO=0.
  - No late write appears in the following 10 cycles.
